// File: rtl/sap_cpu.sv
// SAP-1 style accumulator CPU: one-hot bus mux, five T-states per instruction,
// single-stepped by a clock enable, with a program-load port into its RAM.
module sap_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              fastClk,
    input  logic              rst,
    input  logic              step,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic [ADDR_W-1:0] pc
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} t_state_e;

    localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                           OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                           OP_OUT = 4'hE, OP_HLT = 4'hF;

    localparam int SEL_PC = 0, SEL_RAM = 1, SEL_IR = 2, SEL_A = 3, SEL_ALU = 4, N_SEL = 5;

    t_state_e          t_q, t_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic              carry_q, carry_d, zero_q, zero_d, halted_q, halted_d, out_valid_q, out_valid_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rd, bus;
    logic [N_SEL-1:0]  bus_sel;
    logic [3:0]        opcode;
    logic              is_sub;
    logic [DATA_W:0]   alu_sum;
    logic ld_mar, ld_ir, ld_a, ld_b, ld_out, ld_flags, ld_pc, pc_inc, ram_we, halt_set;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign is_sub  = (opcode == OP_SUB);
    assign alu_sum = {1'b0, a_q} + {1'b0, (is_sub ? ~b_q : b_q)} + (DATA_W+1)'(is_sub);
    assign ram_rd  = mem[mar_q];

    // Control: decode T-state and opcode into bus select and load strobes.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        t_d      = t_q;
        bus_sel  = '0;
        ld_mar   = 1'b0;
        ld_ir    = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_out   = 1'b0;
        ld_flags = 1'b0;
        ld_pc    = 1'b0;
        pc_inc   = 1'b0;
        ram_we   = 1'b0;
        halt_set = 1'b0;
        if (prog_mode) begin
            t_d = T0;
        end else if (step && !halted_q) begin
            t_d = (t_q == T4) ? T0 : t_state_e'(t_q + 3'd1);
            case (t_q)
                T0: begin bus_sel[SEL_PC] = 1'b1; ld_mar = 1'b1; end
                T1: begin bus_sel[SEL_RAM] = 1'b1; ld_ir = 1'b1; pc_inc = 1'b1; end
                T2: case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin bus_sel[SEL_IR] = 1'b1; ld_mar = 1'b1; end
                    OP_LDI: begin bus_sel[SEL_IR] = 1'b1; ld_a = 1'b1; end
                    OP_JMP: begin bus_sel[SEL_IR] = 1'b1; ld_pc = 1'b1; end
                    OP_JC:  begin bus_sel[SEL_IR] = 1'b1; ld_pc = carry_q; end
                    OP_JZ:  begin bus_sel[SEL_IR] = 1'b1; ld_pc = zero_q; end
                    OP_OUT: begin bus_sel[SEL_A] = 1'b1; ld_out = 1'b1; end
                    OP_HLT: begin halt_set = 1'b1; t_d = t_q; end
                    default: ;
                endcase
                T3: case (opcode)
                    OP_LDA:         begin bus_sel[SEL_RAM] = 1'b1; ld_a = 1'b1; end
                    OP_ADD, OP_SUB: begin bus_sel[SEL_RAM] = 1'b1; ld_b = 1'b1; end
                    OP_STA:         begin bus_sel[SEL_A] = 1'b1; ram_we = 1'b1; end
                    default: ;
                endcase
                T4: if (opcode == OP_ADD || opcode == OP_SUB) begin
                    bus_sel[SEL_ALU] = 1'b1;
                    ld_a             = 1'b1;
                    ld_flags         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus = ({DATA_W{bus_sel[SEL_PC]}}  & DATA_W'(pc_q))
               | ({DATA_W{bus_sel[SEL_RAM]}} & ram_rd)
               | ({DATA_W{bus_sel[SEL_IR]}}  & DATA_W'(ir_q[ADDR_W-1:0]))
               | ({DATA_W{bus_sel[SEL_A]}}   & a_q)
               | ({DATA_W{bus_sel[SEL_ALU]}} & alu_sum[DATA_W-1:0]);

    always_comb begin
        mar_d       = ld_mar ? bus[ADDR_W-1:0] : mar_q;
        ir_d        = ld_ir  ? bus : ir_q;
        a_d         = ld_a   ? bus : a_q;
        b_d         = ld_b   ? bus : b_q;
        out_d       = ld_out ? bus : out_q;
        out_valid_d = ld_out;
        carry_d     = ld_flags ? alu_sum[DATA_W] : carry_q;
        zero_d      = ld_flags ? (alu_sum[DATA_W-1:0] == '0) : zero_q;
        pc_d        = pc_q;
        halted_d    = halted_q;
        if (prog_mode) begin
            pc_d     = '0;
            halted_d = 1'b0;
        end else begin
            if (pc_inc)   pc_d     = pc_q + 1'b1;
            if (ld_pc)    pc_d     = bus[ADDR_W-1:0];
            if (halt_set) halted_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fastClk or posedge rst) begin
        if (rst) begin
            t_q         <= T0;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            t_q         <= t_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            halted_q    <= halted_d;
        end
    end

    // NOTE: the RAM array has no reset; rst only blocks a core store in flight.
    always_ff @(posedge fastClk) begin
        if (prog_mode && prog_we) begin
            mem[prog_addr] <= prog_data;
        end else if (ram_we && !rst) begin
            mem[mar_q] <= bus;
        end
    end

    assign out_data   = out_q;
    assign out_valid  = out_valid_q;
    assign halted     = halted_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign pc         = pc_q;

endmodule
